csr_regfile: RTL and testbench

- Machine-mode CSR storage at the consuming end of the MEM/WB CSR write channel (wb_csr_w_addr / wb_csr_w_ena / wb_csr_wdata).
- Commits CSR writes in the WB stage, serves the EX-stage CSR read port with WB->EX bypass, and runs the mcycle/minstret counters.
- Captures trap state (mepc/mcause/mtval/mstatus) and exposes mtvec/mepc to the PC-select logic.
- Single clock; sits beside the integer register file.

---
 rtl/csr_regfile.sv | 196 +++++++++++++++++++
 tb/tb_csr_regfile.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_regfile.sv
// Machine-mode CSR file: WB-stage write commit, EX-stage read port with WB->EX bypass,
// mcycle/minstret counters and trap/mret bookkeeping for mstatus/mepc/mcause/mtval.
module csr_regfile #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] MISA_VAL = 64'h8000_0000_0014_1101
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     wb_csr_w_addr,
  input  logic            wb_csr_w_ena,
  input  logic [XLEN-1:0] wb_csr_wdata,
  input  logic            wb_retire,
  input  logic [11:0]     ex_csr_r_addr,
  input  logic            ex_csr_r_ena,
  output logic [XLEN-1:0] ex_csr_rdata,
  output logic            ex_csr_illegal,
  input  logic            trap_ena,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_ena,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            mie_global_o
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MISA     = 12'h301;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
  localparam logic [11:0] ADDR_INSTRET  = 12'hC02;

  localparam logic [XLEN-1:0] MSTATUS_MASK = XLEN'(8'h88);
  localparam logic [XLEN-1:0] MTVEC_MASK   = ~XLEN'(3);
  localparam logic [XLEN-1:0] MEPC_MASK    = ~XLEN'(1);
  localparam logic [XLEN-1:0] ONE          = XLEN'(1);

  logic            r_mstatus_mie;
  logic            r_mstatus_mpie;
  logic [XLEN-1:0] r_mie;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mtval;
  logic [XLEN-1:0] r_mcycle;
  logic [XLEN-1:0] r_minstret;

  logic w_wr_mstatus;
  logic w_wr_mie;
  logic w_wr_mtvec;
  logic w_wr_mscratch;
  logic w_wr_mepc;
  logic w_wr_mcause;
  logic w_wr_mtval;
  logic w_wr_mcycle;
  logic w_wr_minstret;

  logic [XLEN-1:0] w_mstatus_val;
  logic [XLEN-1:0] w_wdata_masked;

  logic            w_rd_known;
  logic            w_rd_writable;
  logic [11:0]     w_rd_target;
  logic [XLEN-1:0] w_rd_stored;
  logic            w_rd_bypass;

  assign w_wr_mstatus  = wb_csr_w_ena && (wb_csr_w_addr == ADDR_MSTATUS);
  assign w_wr_mie      = wb_csr_w_ena && (wb_csr_w_addr == ADDR_MIE);
  assign w_wr_mtvec    = wb_csr_w_ena && (wb_csr_w_addr == ADDR_MTVEC);
  assign w_wr_mscratch = wb_csr_w_ena && (wb_csr_w_addr == ADDR_MSCRATCH);
  assign w_wr_mepc     = wb_csr_w_ena && (wb_csr_w_addr == ADDR_MEPC);
  assign w_wr_mcause   = wb_csr_w_ena && (wb_csr_w_addr == ADDR_MCAUSE);
  assign w_wr_mtval    = wb_csr_w_ena && (wb_csr_w_addr == ADDR_MTVAL);
  assign w_wr_mcycle   = wb_csr_w_ena && (wb_csr_w_addr == ADDR_MCYCLE);
  assign w_wr_minstret = wb_csr_w_ena && (wb_csr_w_addr == ADDR_MINSTRET);

  always_comb begin
    w_mstatus_val    = '0;
    w_mstatus_val[3] = r_mstatus_mie;
    w_mstatus_val[7] = r_mstatus_mpie;
  end

  // Same masking for the committed value and the bypassed value, so both views agree.
  always_comb begin
    w_wdata_masked = wb_csr_wdata;
    case (wb_csr_w_addr)
      ADDR_MSTATUS: w_wdata_masked = wb_csr_wdata & MSTATUS_MASK;
      ADDR_MTVEC:   w_wdata_masked = wb_csr_wdata & MTVEC_MASK;
      ADDR_MEPC:    w_wdata_masked = wb_csr_wdata & MEPC_MASK;
      default:      w_wdata_masked = wb_csr_wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mtvec        <= '0;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
      r_mcycle       <= '0;
      r_minstret     <= '0;
    end else begin
      if (w_wr_mcycle) r_mcycle <= wb_csr_wdata;
      else             r_mcycle <= r_mcycle + ONE;

      // The CSR-writing instruction's own retirement is swallowed by its write.
      if (w_wr_minstret)  r_minstret <= wb_csr_wdata;
      else if (wb_retire) r_minstret <= r_minstret + ONE;

      if (w_wr_mie)      r_mie      <= wb_csr_wdata;
      if (w_wr_mtvec)    r_mtvec    <= w_wdata_masked;
      if (w_wr_mscratch) r_mscratch <= wb_csr_wdata;

      if (trap_ena) begin
        r_mepc         <= trap_pc & MEPC_MASK;
        r_mcause       <= trap_cause;
        r_mtval        <= trap_tval;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else begin
        if (w_wr_mepc)   r_mepc   <= w_wdata_masked;
        if (w_wr_mcause) r_mcause <= wb_csr_wdata;
        if (w_wr_mtval)  r_mtval  <= wb_csr_wdata;
        if (mret_ena) begin
          r_mstatus_mie  <= r_mstatus_mpie;
          r_mstatus_mpie <= 1'b1;
        end else if (w_wr_mstatus) begin
          r_mstatus_mie  <= wb_csr_wdata[3];
          r_mstatus_mpie <= wb_csr_wdata[7];
        end
      end
    end
  end

  // Aliases resolve to their backing counter so they pick up bypassed counter writes.
  always_comb begin
    w_rd_known    = 1'b1;
    w_rd_writable = 1'b0;
    w_rd_target   = ex_csr_r_addr;
    w_rd_stored   = '0;
    case (ex_csr_r_addr)
      ADDR_MSTATUS:  begin w_rd_stored = w_mstatus_val; w_rd_writable = 1'b1; end
      ADDR_MISA:     w_rd_stored = MISA_VAL;
      ADDR_MIE:      begin w_rd_stored = r_mie;         w_rd_writable = 1'b1; end
      ADDR_MTVEC:    begin w_rd_stored = r_mtvec;       w_rd_writable = 1'b1; end
      ADDR_MSCRATCH: begin w_rd_stored = r_mscratch;    w_rd_writable = 1'b1; end
      ADDR_MEPC:     begin w_rd_stored = r_mepc;        w_rd_writable = 1'b1; end
      ADDR_MCAUSE:   begin w_rd_stored = r_mcause;      w_rd_writable = 1'b1; end
      ADDR_MTVAL:    begin w_rd_stored = r_mtval;       w_rd_writable = 1'b1; end
      ADDR_MIP:      w_rd_stored = '0;
      ADDR_MCYCLE:   begin w_rd_stored = r_mcycle;      w_rd_writable = 1'b1; end
      ADDR_MINSTRET: begin w_rd_stored = r_minstret;    w_rd_writable = 1'b1; end
      ADDR_CYCLE: begin
        w_rd_stored   = r_mcycle;
        w_rd_writable = 1'b1;
        w_rd_target   = ADDR_MCYCLE;
      end
      ADDR_INSTRET: begin
        w_rd_stored   = r_minstret;
        w_rd_writable = 1'b1;
        w_rd_target   = ADDR_MINSTRET;
      end
      default: w_rd_known = 1'b0;
    endcase
  end

  assign w_rd_bypass = w_rd_writable && wb_csr_w_ena && (wb_csr_w_addr == w_rd_target);

  always_comb begin
    ex_csr_rdata   = '0;
    ex_csr_illegal = 1'b0;
    if (ex_csr_r_ena) begin
      if (!w_rd_known)      ex_csr_illegal = 1'b1;
      else if (w_rd_bypass) ex_csr_rdata   = w_wdata_masked;
      else                  ex_csr_rdata   = w_rd_stored;
    end
  end

  assign mtvec_o      = r_mtvec;
  assign mepc_o       = r_mepc;
  assign mie_global_o = r_mstatus_mie;

endmodule

// File: tb/tb_csr_regfile.sv
// Scoreboarded bench for csr_regfile: driver pushes model expectations, monitor pops and
// compares on the opposite clock edge. Directed test-plan steps, then randomized traffic.
module tb_csr_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] wb_csr_w_addr;
  logic        wb_csr_w_ena;
  logic [63:0] wb_csr_wdata;
  logic        wb_retire;
  logic [11:0] ex_csr_r_addr;
  logic        ex_csr_r_ena;
  logic [63:0] ex_csr_rdata;
  logic        ex_csr_illegal;
  logic        trap_ena;
  logic [63:0] trap_pc;
  logic [63:0] trap_cause;
  logic [63:0] trap_tval;
  logic        mret_ena;
  logic [63:0] mtvec_o;
  logic [63:0] mepc_o;
  logic        mie_global_o;

  localparam logic [63:0] MISA = 64'h8000_0000_0014_1101;

  csr_regfile dut (
    .clk(clk), .rst(rst),
    .wb_csr_w_addr(wb_csr_w_addr), .wb_csr_w_ena(wb_csr_w_ena), .wb_csr_wdata(wb_csr_wdata),
    .wb_retire(wb_retire),
    .ex_csr_r_addr(ex_csr_r_addr), .ex_csr_r_ena(ex_csr_r_ena),
    .ex_csr_rdata(ex_csr_rdata), .ex_csr_illegal(ex_csr_illegal),
    .trap_ena(trap_ena), .trap_pc(trap_pc), .trap_cause(trap_cause), .trap_tval(trap_tval),
    .mret_ena(mret_ena),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mie_global_o(mie_global_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        w_ena;
    logic [11:0] w_addr;
    logic [63:0] wdata;
    logic        retire;
    logic        r_ena;
    logic [11:0] r_addr;
    logic        trap;
    logic [63:0] tpc;
    logic [63:0] tcause;
    logic [63:0] ttval;
    logic        mret;
  } txn_t;

  typedef struct {
    int          id;
    logic [11:0] addr;
    logic [63:0] rdata;
    logic        illegal;
    logic [63:0] mtvec;
    logic [63:0] mepc;
    logic        mie;
    bit          has_const;
    logic [63:0] cval;
  } exp_t;

  exp_t        expq[$];
  int          checks = 0;
  int          errors = 0;
  int          n_txn  = 0;
  logic [63:0] m [0:4095];

  // Reference model: a flat CSR address space plus per-address rules.
  function automatic bit implemented(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
      12'hB00, 12'hB02, 12'hC00, 12'hC02: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit writable(input logic [11:0] a);
    case (a)
      12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'hB00, 12'hB02:
        return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] wmask(input logic [11:0] a);
    case (a)
      12'h300: return 64'h88;
      12'h305: return ~64'h3;
      12'h341: return ~64'h1;
      default: return ~64'h0;
    endcase
  endfunction

  function automatic void model_read(input txn_t t, output logic [63:0] rd, output logic ill);
    logic [11:0] a;
    rd  = '0;
    ill = 1'b0;
    if (!t.r_ena) return;
    if (!implemented(t.r_addr)) begin
      ill = 1'b1;
      return;
    end
    a = t.r_addr;
    if (a == 12'hC00) a = 12'hB00;
    if (a == 12'hC02) a = 12'hB02;
    if (t.w_ena && t.w_addr == a && writable(a)) rd = t.wdata & wmask(a);
    else if (a == 12'h301) rd = MISA;
    else if (a == 12'h344) rd = '0;
    else rd = m[a];
  endfunction

  function automatic void model_commit(input txn_t t);
    logic [63:0] ms_old;
    bit          blocked;
    if (t.rst) begin
      for (int i = 0; i < 4096; i++) m[i] = '0;
      return;
    end
    ms_old = m[12'h300];
    m[12'hB00] = m[12'hB00] + 64'd1;
    if (t.retire) m[12'hB02] = m[12'hB02] + 64'd1;
    if (t.w_ena && writable(t.w_addr)) begin
      blocked = (t.trap && (t.w_addr == 12'h300 || t.w_addr == 12'h341 ||
                            t.w_addr == 12'h342 || t.w_addr == 12'h343)) ||
                (t.mret && t.w_addr == 12'h300);
      if (!blocked) m[t.w_addr] = t.wdata & wmask(t.w_addr);
    end
    if (t.trap) begin
      m[12'h341] = t.tpc & ~64'h1;
      m[12'h342] = t.tcause;
      m[12'h343] = t.ttval;
      m[12'h300] = ms_old[3] ? 64'h80 : 64'h0;
    end else if (t.mret) begin
      m[12'h300] = 64'h80 | (ms_old[7] ? 64'h8 : 64'h0);
    end
  endfunction

  function automatic txn_t idle();
    txn_t t;
    t.rst = 0; t.w_ena = 0; t.w_addr = '0; t.wdata = '0; t.retire = 0;
    t.r_ena = 0; t.r_addr = '0; t.trap = 0; t.tpc = '0; t.tcause = '0; t.ttval = '0;
    t.mret = 0;
    return t;
  endfunction

  function automatic txn_t rd(input logic [11:0] a);
    txn_t t = idle();
    t.r_ena = 1; t.r_addr = a;
    return t;
  endfunction

  function automatic txn_t wr(input logic [11:0] a, input logic [63:0] d);
    txn_t t = idle();
    t.w_ena = 1; t.w_addr = a; t.wdata = d;
    return t;
  endfunction

  // Called at posedge+1: model state equals DUT state after the edge just passed.
  task automatic step(input txn_t t, input bit has_const, input logic [63:0] cval);
    exp_t e;
    rst = t.rst; wb_csr_w_ena = t.w_ena; wb_csr_w_addr = t.w_addr; wb_csr_wdata = t.wdata;
    wb_retire = t.retire; ex_csr_r_ena = t.r_ena; ex_csr_r_addr = t.r_addr;
    trap_ena = t.trap; trap_pc = t.tpc; trap_cause = t.tcause; trap_tval = t.ttval;
    mret_ena = t.mret;
    model_read(t, e.rdata, e.illegal);
    e.id = n_txn; e.addr = t.r_addr;
    e.mtvec = m[12'h305]; e.mepc = m[12'h341]; e.mie = m[12'h300][3];
    e.has_const = has_const; e.cval = cval;
    expq.push_back(e);
    n_txn++;
    model_commit(t);
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input int id, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL txn %0d %s: got %h expected %h", id, name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        cmp("rdata",   e.id, ex_csr_rdata, e.rdata);
        cmp("illegal", e.id, {63'd0, ex_csr_illegal}, {63'd0, e.illegal});
        cmp("mtvec_o", e.id, mtvec_o, e.mtvec);
        cmp("mepc_o",  e.id, mepc_o, e.mepc);
        cmp("mie",     e.id, {63'd0, mie_global_o}, {63'd0, e.mie});
        if (e.has_const) cmp("plan_rdata", e.id, ex_csr_rdata, e.cval);
        $display("txn %0d raddr %h rdata %h ill %0d mtvec %h mepc %h mie %0d",
                 e.id, e.addr, ex_csr_rdata, ex_csr_illegal, mtvec_o, mepc_o, mie_global_o);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  logic [11:0] addr_tab [0:15];

  initial begin : driver
    txn_t t;
    addr_tab = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                 12'h344, 12'hB00, 12'hB02, 12'hC00, 12'hC02, 12'h7C0, 12'h000, 12'hB01};

    t = idle(); t.rst = 1;
    rst = 1; wb_csr_w_ena = 0; wb_csr_w_addr = '0; wb_csr_wdata = '0; wb_retire = 0;
    ex_csr_r_ena = 0; ex_csr_r_addr = '0; trap_ena = 0; trap_pc = '0; trap_cause = '0;
    trap_tval = '0; mret_ena = 0;
    @(posedge clk);
    #1;
    model_commit(t);
    step(t, 0, 0);
    step(t, 0, 0);

    // Reset release and mcycle start-up
    t = rd(12'hB00);
    step(t, 1, 64'd0);
    step(t, 1, 64'd1);
    step(t, 1, 64'd2);
    step(t, 1, 64'd3);

    // mscratch write with same-cycle bypass
    t = wr(12'h340, 64'hDEAD_BEEF); t.r_ena = 1; t.r_addr = 12'h340;
    step(t, 1, 64'hDEAD_BEEF);
    step(rd(12'h340), 1, 64'hDEAD_BEEF);

    // mtvec masking, misa read-only, unimplemented read
    step(wr(12'h305, 64'h8000_0103), 0, 0);
    step(rd(12'h305), 1, 64'h8000_0100);
    step(wr(12'h301, 64'h0), 0, 0);
    step(rd(12'h301), 1, MISA);
    step(rd(12'h7C0), 1, 64'h0);

    // Trap over a same-cycle mepc write, then mret
    step(wr(12'h300, 64'h8), 0, 0);
    t = wr(12'h341, 64'h1234);
    t.trap = 1; t.tpc = 64'h8000_1235; t.tcause = 64'hB; t.ttval = 64'h0;
    step(t, 0, 0);
    step(rd(12'h341), 1, 64'h8000_1234);
    step(rd(12'h342), 1, 64'hB);
    step(rd(12'h300), 1, 64'h80);
    t = idle(); t.mret = 1;
    step(t, 0, 0);
    step(rd(12'h300), 1, 64'h88);

    // minstret wrap, alias reads
    t = wr(12'hB02, 64'hFFFF_FFFF_FFFF_FFFF); t.retire = 1;
    step(t, 0, 0);
    step(rd(12'hC02), 1, 64'hFFFF_FFFF_FFFF_FFFF);
    t = rd(12'hB02); t.retire = 1;
    step(t, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    step(rd(12'hC02), 1, 64'h0);

    // Bubble ignored; reset beats a pending write
    t = rd(12'h340); t.w_addr = 12'h340; t.wdata = 64'h55;
    step(t, 1, 64'hDEAD_BEEF);
    step(rd(12'h340), 1, 64'hDEAD_BEEF);
    t = wr(12'h340, 64'h1111); t.rst = 1;
    step(t, 0, 0);
    step(rd(12'h340), 1, 64'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      t = idle();
      t.rst    = ($urandom_range(0, 63) == 0);
      t.w_ena  = ($urandom_range(0, 2) != 0);
      t.w_addr = addr_tab[$urandom_range(0, 15)];
      t.wdata  = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF
                                              : {$urandom(), $urandom()};
      t.retire = $urandom_range(0, 1) == 1;
      t.r_ena  = ($urandom_range(0, 7) != 0);
      t.r_addr = ($urandom_range(0, 3) == 0) ? t.w_addr : addr_tab[$urandom_range(0, 15)];
      t.trap   = ($urandom_range(0, 11) == 0);
      t.tpc    = {$urandom(), $urandom()};
      t.tcause = {$urandom(), $urandom()};
      t.ttval  = {$urandom(), $urandom()};
      t.mret   = ($urandom_range(0, 9) == 0);
      step(t, 0, 0);
    end

    t = idle();
    rst = t.rst; wb_csr_w_ena = 0; ex_csr_r_ena = 0; trap_ena = 0; mret_ena = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
